// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter_pkg
// Brief    : Shared types and sizes for the CDB arbiter and its per-FU FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    localparam int NUM_FU_ALU   = 1;
    localparam int NUM_FU_MULT  = 1;
    localparam int NUM_FU_LD    = 1;
    localparam int NUM_FU_STORE = 1;
    localparam int NUM_FU_BR    = 0;
    localparam int CDB_N        = 2;

    localparam int BR_MASK_W    = 4;
    localparam int REG_IDX_W    = 6;
    localparam int VALUE_W      = 32;

    typedef logic [BR_MASK_W-1:0] BR_MASK;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        CLEAR   = 2'd1,
        SQUASH  = 2'd2
    } BR_TASK;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] reg_idx;
        logic [VALUE_W-1:0]   value;
        BR_MASK               b_mask;
    } FU_RESULT_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] reg_idx;
        logic [VALUE_W-1:0]   value;
    } CDB_PACKET;

    function automatic logic br_hit(input BR_MASK mask, input BR_MASK id);
        return |(mask & id);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fu_result_fifo
// Brief    : Per-FU result buffer with branch squash/clear and age-ordered compaction.
// Revision : 1.0 - initial release
// ============================================================================
module fu_result_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  FU_RESULT_PACKET in_pkt,
    input  BR_MASK          br_id,
    input  BR_TASK          br_task,
    input  logic            pop,
    output CDB_PACKET       head,
    output logic            full
);

    localparam int CW = $clog2(DEPTH + 1);

    FU_RESULT_PACKET  r_mem  [DEPTH];
    logic [CW-1:0]    r_count;

    FU_RESULT_PACKET  w_ent  [DEPTH];
    logic [DEPTH-1:0] w_keep;
    int               w_pos  [DEPTH+1];
    FU_RESULT_PACKET  w_surv [DEPTH+1];
    FU_RESULT_PACKET  w_next [DEPTH];
    FU_RESULT_PACKET  w_in;
    int               w_base;
    int               w_ncount;
    logic             w_squash;
    logic             w_clear;
    logic             w_push;

    assign w_squash = (br_task == SQUASH);
    assign w_clear  = (br_task == CLEAR);
    assign full     = (r_count == CW'(DEPTH));

    always_comb begin : comb_in
        w_in = in_pkt;
        if (w_clear && br_hit(in_pkt.b_mask, br_id))
            w_in.b_mask = in_pkt.b_mask ^ br_id;
        w_push = in_pkt.valid && !full && !(w_squash && br_hit(in_pkt.b_mask, br_id));
    end

    // Survivors are packed toward slot 0 keeping their original age order.
    always_comb begin : comb_filter
        w_pos[0] = 0;
        for (int k = 0; k < DEPTH; k++) begin
            w_ent[k] = r_mem[k];
            if (w_clear && br_hit(r_mem[k].b_mask, br_id))
                w_ent[k].b_mask = r_mem[k].b_mask ^ br_id;
            w_keep[k]  = (k < int'(r_count)) && r_mem[k].valid &&
                         !(w_squash && br_hit(r_mem[k].b_mask, br_id));
            w_pos[k+1] = w_pos[k] + (w_keep[k] ? 1 : 0);
        end
        for (int j = 0; j <= DEPTH; j++) begin
            w_surv[j] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (w_keep[k] && (w_pos[k] == j))
                    w_surv[j] = w_ent[k];
            end
        end
    end

    always_comb begin : comb_next
        w_base = w_pos[DEPTH] - (pop ? 1 : 0);
        for (int j = 0; j < DEPTH; j++) begin
            w_next[j] = pop ? w_surv[j+1] : w_surv[j];
            if (w_push && (w_base == j))
                w_next[j] = w_in;
        end
        w_ncount = w_base + (w_push ? 1 : 0);
    end

    assign head.valid   = (w_pos[DEPTH] != 0);
    assign head.reg_idx = w_surv[0].reg_idx;
    assign head.value   = w_surv[0].value;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            for (int k = 0; k < DEPTH; k++)
                r_mem[k] <= '0;
        end else begin
            r_count <= CW'(w_ncount);
            for (int k = 0; k < DEPTH; k++)
                r_mem[k] <= w_next[k];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Buffers FU results and broadcasts up to N per cycle on the CDB.
//            Define CDB_RR_EN for round-robin priority; fixed priority otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N          = CDB_N,
    parameter int NUM_FU     = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LD + NUM_FU_STORE + NUM_FU_BR,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  FU_RESULT_PACKET fu_out   [NUM_FU],
    input  BR_MASK          br_id,
    input  BR_TASK          br_task,
    output logic [NUM_FU-1:0] fu_stall,
    output CDB_PACKET       cdb_out  [N]
);

    CDB_PACKET         w_head     [NUM_FU];
    logic [NUM_FU-1:0] w_pop;
    CDB_PACKET         w_cdb_next [N];
    int                w_ngrant;
    int                w_last;
    int                w_start;

    generate
        for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
            fu_result_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clock   (clock),
                .reset   (reset),
                .in_pkt  (fu_out[g]),
                .br_id   (br_id),
                .br_task (br_task),
                .pop     (w_pop[g]),
                .head    (w_head[g]),
                .full    (fu_stall[g])
            );
        end
    endgenerate

`ifdef CDB_RR_EN
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    logic [PW-1:0] r_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_ptr <= '0;
        else if (w_ngrant != 0)
            r_ptr <= PW'((w_last + 1) % NUM_FU);
    end

    assign w_start = int'(r_ptr);
`else
    assign w_start = 0;
`endif

    // Walk FUs in priority rank order; each granted head takes the next free slot.
    always_comb begin : comb_grant
        w_pop    = '0;
        w_ngrant = 0;
        w_last   = 0;
        for (int s = 0; s < N; s++)
            w_cdb_next[s] = '0;
        for (int r = 0; r < NUM_FU; r++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if ((((w_start + r) % NUM_FU) == i) && w_head[i].valid && (w_ngrant < N)) begin
                    w_pop[i] = 1'b1;
                    for (int s = 0; s < N; s++) begin
                        if (s == w_ngrant)
                            w_cdb_next[s] = w_head[i];
                    end
                    w_ngrant = w_ngrant + 1;
                    w_last   = i;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < N; s++)
                cdb_out[s] <= '0;
        end else begin
            for (int s = 0; s < N; s++)
                cdb_out[s] <= w_cdb_next[s];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Scoreboard bench for cdb_arbiter (N=2, NUM_FU=4, FIFO_DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NB    = 2;
    localparam int NFU   = 4;
    localparam int DEPTH = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    FU_RESULT_PACKET fu_out [NFU];
    BR_MASK          br_id;
    BR_TASK          br_task;
    logic [NFU-1:0]  fu_stall;
    CDB_PACKET       cdb_out [NB];

    cdb_arbiter #(
        .N          (NB),
        .NUM_FU     (NFU),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .fu_out   (fu_out),
        .br_id    (br_id),
        .br_task  (br_task),
        .fu_stall (fu_stall),
        .cdb_out  (cdb_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0]  reg_idx;
        logic [31:0] value;
        BR_MASK      mask;
    } exp_t;

    exp_t            q [NFU][$];
    FU_RESULT_PACKET pend [NFU];
    logic [NFU-1:0]  has_pend;
    logic [NFU-1:0]  active;
    logic            rnd_mask;
    int              seq;
    int              checks = 0;
    int              errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic inject(input int i, input logic [5:0] r, input BR_MASK m);
        pend[i].valid   = 1'b1;
        pend[i].reg_idx = r;
        pend[i].value   = {4'(i), 28'(seq)};
        pend[i].b_mask  = m;
        has_pend[i]     = 1'b1;
        seq++;
    endtask

    task automatic drive(input BR_TASK t, input BR_MASK id);
        br_task = t;
        br_id   = id;
        for (int i = 0; i < NFU; i++) begin
            exp_t keep[$];
            keep.delete();
            for (int k = 0; k < q[i].size(); k++) begin
                exp_t e;
                e = q[i][k];
                if (!((t == SQUASH) && |(e.mask & id))) begin
                    if ((t == CLEAR) && |(e.mask & id))
                        e.mask = e.mask ^ id;
                    keep.push_back(e);
                end
            end
            q[i] = keep;
        end
        for (int i = 0; i < NFU; i++) begin
            if (active[i] && !has_pend[i])
                inject(i, 6'($urandom_range(0, 63)), rnd_mask ? BR_MASK'($urandom_range(0, 3)) : '0);
            if (has_pend[i]) begin
                fu_out[i] = pend[i];
                if ((t == SQUASH) && |(pend[i].b_mask & id)) begin
                    has_pend[i] = 1'b0;
                end else begin
                    if ((t == CLEAR) && |(pend[i].b_mask & id))
                        pend[i].b_mask = pend[i].b_mask ^ id;
                    if (!fu_stall[i]) begin
                        exp_t e;
                        e.reg_idx = pend[i].reg_idx;
                        e.value   = pend[i].value;
                        e.mask    = pend[i].b_mask;
                        q[i].push_back(e);
                        has_pend[i] = 1'b0;
                    end
                end
            end else begin
                fu_out[i] = '0;
            end
        end
    endtask

    task automatic monitor();
        for (int s = 0; s < NB; s++) begin
            if (cdb_out[s].valid) begin
                int f;
                f = int'(cdb_out[s].value[31:28]);
                if (s > 0) begin
                    check_eq("slot_packed", cdb_out[s-1].valid, 1);
                    check_eq("slot_fu_distinct", cdb_out[s].value[31:28] != cdb_out[0].value[31:28], 1);
                end
                if ((f < NFU) && (q[f].size() > 0)) begin
                    exp_t e;
                    e = q[f].pop_front();
                    check_eq("cdb_reg", cdb_out[s].reg_idx, e.reg_idx);
                    check_eq("cdb_val", cdb_out[s].value, e.value);
                end else begin
                    check_eq("cdb_spurious", cdb_out[s].valid, 0);
                end
            end else begin
                check_eq("slot_zero", cdb_out[s], 0);
            end
        end
        for (int i = 0; i < NFU; i++)
            check_eq("stall", fu_stall[i], q[i].size() >= DEPTH);
    endtask

    task automatic cycle(input BR_TASK t, input BR_MASK id);
        drive(t, id);
        @(posedge clock);
        @(negedge clock);
        monitor();
    endtask

    function automatic int fu_of(input int s);
        return int'(cdb_out[s].value[31:28]);
    endfunction

    initial begin
        int left;
        br_task  = NOTHING;
        br_id    = '0;
        has_pend = '0;
        active   = '0;
        rnd_mask = 1'b0;
        seq      = 0;
        for (int i = 0; i < NFU; i++) fu_out[i] = '0;

        repeat (2) @(negedge clock);
        check_eq("rst_stall", fu_stall, 0);
        check_eq("rst_cdb0", cdb_out[0], 0);
        check_eq("rst_cdb1", cdb_out[1], 0);
        reset = 1'b1;

        // Four simultaneous results drain two per cycle in FU order.
        for (int i = 0; i < NFU; i++) inject(i, 6'(5 + i), '0);
        cycle(NOTHING, '0);
        check_eq("t1_latency", cdb_out[0].valid, 0);
        cycle(NOTHING, '0);
        check_eq("t1_c1_s0", cdb_out[0].reg_idx, 5);
        check_eq("t1_c1_s1", cdb_out[1].reg_idx, 6);
        cycle(NOTHING, '0);
        check_eq("t1_c2_s0", cdb_out[0].reg_idx, 7);
        check_eq("t1_c2_s1", cdb_out[1].reg_idx, 8);
        cycle(NOTHING, '0);
        check_eq("t1_empty", cdb_out[0].valid, 0);

        // Clear on an incoming packet protects it from a later squash of that branch.
        inject(0, 6'd20, 4'b0011);
        cycle(CLEAR, 4'b0001);
        cycle(SQUASH, 4'b0001);
        check_eq("clr_valid", cdb_out[0].valid, 1);
        check_eq("clr_reg", cdb_out[0].reg_idx, 20);

        // A buffered head squashed on its pop cycle is never broadcast.
        inject(1, 6'd21, 4'b0010);
        cycle(NOTHING, '0);
        cycle(SQUASH, 4'b0010);
        check_eq("sq_head_gone", cdb_out[0].valid, 0);
        cycle(NOTHING, '0);
        check_eq("sq_head_gone2", cdb_out[0].valid, 0);

        // Incoming squash drops only the matching packet.
        inject(2, 6'd22, 4'b0010);
        inject(3, 6'd23, 4'b0001);
        cycle(SQUASH, 4'b0010);
        cycle(NOTHING, '0);
        check_eq("sq_in_s0", cdb_out[0].reg_idx, 23);
        check_eq("sq_in_s1", cdb_out[1].valid, 0);

        // Saturate, then assert reset asynchronously mid-cycle.
        active = '1;
        repeat (6) cycle(NOTHING, '0);
        check_eq("pre_rst_stall", |fu_stall, 1);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_stall", fu_stall, 0);
        check_eq("arst_cdb0", cdb_out[0], 0);
        check_eq("arst_cdb1", cdb_out[1], 0);
        active   = '0;
        has_pend = '0;
        for (int i = 0; i < NFU; i++) begin
            q[i].delete();
            fu_out[i] = '0;
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) cycle(NOTHING, '0);
        check_eq("post_rst_idle", cdb_out[0].valid, 0);
        inject(3, 6'd40, '0);
        cycle(NOTHING, '0);
        cycle(NOTHING, '0);
        check_eq("post_rst_first", cdb_out[0].reg_idx, 40);
        cycle(NOTHING, '0);

        // All FUs permanently busy: grant pattern depends on priority scheme.
        active = '1;
        cycle(NOTHING, '0);
        for (int k = 0; k < 3; k++) begin
            int e0;
            cycle(NOTHING, '0);
`ifdef CDB_RR_EN
            e0 = (k % 2 == 0) ? 0 : 2;
`else
            e0 = 0;
`endif
            check_eq("arb_s0_fu", fu_of(0), e0);
            check_eq("arb_s1_fu", fu_of(1), e0 + 1);
        end
        repeat (3) cycle(NOTHING, '0);
`ifndef CDB_RR_EN
        check_eq("fixed_starve_stall", fu_stall[3:2], 2'b11);
`endif

        // Random traffic with branch masks, clears and squashes.
        rnd_mask = 1'b1;
        for (int c = 0; c < 400; c++) begin
            int r;
            BR_TASK t;
            r = $urandom_range(0, 9);
            t = (r == 0) ? SQUASH : (r == 1) ? CLEAR : NOTHING;
            active = NFU'($urandom_range(0, 15));
            cycle(t, BR_MASK'(1 << $urandom_range(0, 1)));
        end

        active = '0;
        for (int c = 0; c < 60; c++) begin
            left = 0;
            for (int i = 0; i < NFU; i++) left += q[i].size() + (has_pend[i] ? 1 : 0);
            if (left == 0) break;
            cycle(NOTHING, '0);
        end
        left = 0;
        for (int i = 0; i < NFU; i++) left += q[i].size() + (has_pend[i] ? 1 : 0);
        check_eq("drain_left", left, 0);
        repeat (3) cycle(NOTHING, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from all functional units, buffers them per FU, and broadcasts up to N results per cycle on the common data bus (CDB) consumed by the reservation station, map table and ROB. Back-pressures FUs with per-FU stall bits when buffering is exhausted, and honours branch squash/clear so that no mispredicted result is ever broadcast. Sits between the FU pipelines and every CDB consumer.

## Interface
- `N`, default `` `N ``: CDB width, results broadcast per cycle.
- `NUM_FU`, default `` `NUM_FU_ALU+`NUM_FU_MULT+`NUM_FU_LD+`NUM_FU_STORE+`NUM_FU_BR ``: number of result producers.
- `FIFO_DEPTH`, default 2: result slots per FU.

- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `fu_out`  in  `FU_RESULT_PACKET [NUM_FU]`  completed result per FU: `valid`, `reg_idx`, `value`, `b_mask`.
- `br_id`  in  `BR_MASK`  one-hot branch being resolved.
- `br_task`  in  `BR_TASK`  NOTHING / CLEAR / SQUASH.
- `fu_stall`  out  `NUM_FU`  FU i must hold its result and not present new ones.
- `cdb_out`  out  `CDB_PACKET [N]`  broadcast results: `valid`, `reg_idx`, `value`.

## Operation
- Per FU: FIFO of `FIFO_DEPTH` entries, count width `$clog2(FIFO_DEPTH+1)`.
- Push: `fu_out[i].valid && !fu_stall[i]` and not squashed this cycle. Valid input while stalled is ignored; FU must re-present it.
- `fu_stall[i] = (count[i] == FIFO_DEPTH)`, from registered state only; no same-cycle dependence on grants or inputs.
- Squash (`br_task==SQUASH`): every FIFO entry and every incoming `fu_out` with `(b_mask & br_id) != 0` is dropped; survivors compact in age order; counts decrement accordingly.
- Clear (`br_task==CLEAR`): matching entries and incoming packets get `b_mask ^= br_id`.
- Grant: candidates are non-empty FIFO heads after the squash filter. Up to N granted per cycle, one per FU max, in priority order (see Configuration). Granted heads pop.
- Empty FIFO: an incoming result is not granted in the same cycle (no combinational bypass).
- `cdb_out` slots filled from slot 0 upward in priority order; unused slots all-zero.

## Timing
- Reset: all FIFOs empty, `fu_stall` = 0, `cdb_out` = 0, RR pointer = 0.
- Latency: result accepted at edge t is broadcast at earliest cycle t+1 (`cdb_out` is registered).
- Push and pop on the same FU in one cycle are legal; count stays unchanged.
- A FIFO going full at edge t asserts `fu_stall` from cycle t+1.
- Squash in cycle t does not recall the `cdb_out` already visible in cycle t. Squash does remove entries from the value loaded at edge t.
- Squash concurrent with pop: a squashed head is neither granted nor broadcast.
- Reset mid-operation: immediate asynchronous clear of all state and outputs.

## Configuration
- `CDB_RR_EN` defined: round-robin priority. The pointer starts at FU 0. After a cycle with grants, it moves to (last granted FU index + 1) mod `NUM_FU`. With no grants, it holds.
- Not defined: fixed priority, lowest FU index first, no pointer state.

## Structure
- `sys_defs.svh`: `FU_RESULT_PACKET`, `CDB_PACKET`, `BR_MASK`, `BR_TASK`, `NUM_FU_*`, `N`.
- Sub-module `fu_result_fifo` covers one FU: push, pop, squash/clear, compaction and count, instantiated `NUM_FU` times. Arbitration and the output register live in the top.

## Test plan
- N=2, NUM_FU=4. FUs 0–3 each push one result in cycle 0 (reg 5,6,7,8) -> cycle 1 broadcasts regs 5,6. Cycle 2 broadcasts regs 7,8. No stalls.
- FU 1 pushes every cycle while FUs 0,2,3 also push continuously, FIFO_DEPTH=2 -> `fu_stall[1]` rises once its count hits 2. Inputs presented during stall are not lost after the FU holds them. Broadcast order per FU is preserved.
- FU 2 FIFO holds entries with b_mask 0b01 and 0b10; SQUASH with br_id=0b10 -> only the 0b10 entry vanishes, count drops 2→1. That entry never appears on `cdb_out`.
- CLEAR with br_id=0b01 on a buffered entry with b_mask 0b11 -> b_mask becomes 0b10. A later SQUASH with br_id=0b01 leaves it intact.
- With `CDB_RR_EN`, all 4 FUs permanently non-empty -> grants alternate {0,1},{2,3},{0,1}. Without the macro -> always {0,1}, and FUs 2,3 eventually stall.
- Reset asserted while FIFOs are full -> `fu_stall` and `cdb_out` go to 0 immediately. After release, first broadcast only follows new pushes.
